reg_scoreboard: RTL and testbench

- Register-hazard scoreboard that sequences register-file access for the decode stage of the 5-stage pipeline.
- Keeps a per-register count of in-flight writes: incremented when decode issues a register-writing instruction, decremented when the write-back stage commits it or a later stage kills it.
- Raises a combinational stall to decode while any operand it reads, or the register it will write, is still pending.
- Sits beside the register file and control unit; its stall gates the IF/ID latch and injects a bubble into ID/EX.

---
 rtl/reg_scoreboard_if.sv | 42 ++++
 rtl/reg_scoreboard.sv | 102 ++++++++++
 tb/tb_reg_scoreboard.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - decode, write-back and kill bundle for reg_scoreboard
//
// Purpose: groups the pipeline-facing signals of the register scoreboard.
// Ports (master = pipeline side, slave = scoreboard side):
//   issue_valid/src/dst/rd_src/rd_dst/wr  decode instruction and its register use
//   flush                                 kill the instruction currently in decode
//   wb_valid/wb_addr                      write-back register commit
//   kill_valid/kill_addr                  squashed in-flight writer
//   stall                                 combinational decode hold
//   busy_mask                             one bit per register with writes pending
//   sb_err                                sticky counter underflow
interface reg_scoreboard_if #(
   parameter int AW   = 3,
   parameter int NREG = 2**AW
);
   logic            issue_valid;
   logic [AW-1:0]   issue_src;
   logic [AW-1:0]   issue_dst;
   logic            issue_rd_src;
   logic            issue_rd_dst;
   logic            issue_wr;
   logic            flush;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic            kill_valid;
   logic [AW-1:0]   kill_addr;
   logic            stall;
   logic [NREG-1:0] busy_mask;
   logic            sb_err;

   modport master (
      output issue_valid, issue_src, issue_dst, issue_rd_src, issue_rd_dst, issue_wr,
      output flush, wb_valid, wb_addr, kill_valid, kill_addr,
      input  stall, busy_mask, sb_err
   );

   modport slave (
      input  issue_valid, issue_src, issue_dst, issue_rd_src, issue_rd_dst, issue_wr,
      input  flush, wb_valid, wb_addr, kill_valid, kill_addr,
      output stall, busy_mask, sb_err
   );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register-hazard scoreboard for the decode stage
//
// Purpose: counts in-flight writes per architectural register and stalls
// decode while an operand or the destination is still pending.
// Ports:
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-low reset
//   sb            reg_scoreboard_if.slave (issue, flush, wb, kill, stall, busy_mask, sb_err)
//   stats_clr     synchronous clear of stall_cycles      (SB_STATS_EN only)
//   stall_cycles  saturating count of stalled cycles     (SB_STATS_EN only)
// Optional feature macro: SB_STATS_EN
module reg_scoreboard #(
   parameter int AW   = 3,
   parameter int NREG = 2**AW,
   parameter int CW   = 2
) (
   input  logic        clk,
   input  logic        rst,
`ifdef SB_STATS_EN
   input  logic        stats_clr,
   output logic [15:0] stall_cycles,
`endif
   reg_scoreboard_if.slave sb
);
   localparam logic [CW-1:0] MAXP = {CW{1'b1}};

   logic [CW-1:0] cnt     [NREG];
   logic [CW-1:0] cnt_nxt [NREG];
   logic          sb_err_q;
   logic          err_nxt;
   logic          hazard;
   logic          stall;
   logic          accept;
   logic [NREG-1:0] busy;

   // per-register scratch for the next-count computation
   logic          inc;
   logic [1:0]    dec;
   logic [CW+1:0] avail;

   // Hazards use the counts before this instruction's own increment, so a
   // src==dst instruction on an idle register does not stall on itself.
   always_comb begin
      hazard = (sb.issue_rd_src && (cnt[sb.issue_src] != '0))
             || (sb.issue_rd_dst && (cnt[sb.issue_dst] != '0))
             || (sb.issue_wr     && (cnt[sb.issue_dst] == MAXP));
      stall  = sb.issue_valid && !sb.flush && hazard;
      accept = sb.issue_valid && !sb.flush && !stall;
   end

   // Increments and decrements are netted before clamping, so a same-edge
   // issue and write-back on one register leaves its count unchanged.
   always_comb begin
      err_nxt = sb_err_q;
      inc     = 1'b0;
      dec     = 2'd0;
      avail   = '0;
      for (int r = 0; r < NREG; r++) begin
         inc   = accept && sb.issue_wr && (sb.issue_dst == AW'(r));
         dec   = {1'b0, sb.wb_valid && (sb.wb_addr == AW'(r))}
               + {1'b0, sb.kill_valid && (sb.kill_addr == AW'(r))};
         avail = (CW+2)'(cnt[r]) + (CW+2)'(inc);
         if ((CW+2)'(dec) > avail) begin
            cnt_nxt[r] = '0;
            err_nxt    = 1'b1;
         end else begin
            cnt_nxt[r] = CW'(avail - (CW+2)'(dec));
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
         sb_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
         sb_err_q <= err_nxt;
      end
   end

   always_comb begin
      busy = '0;
      for (int r = 0; r < NREG; r++) busy[r] = (cnt[r] != '0);
   end

   assign sb.stall     = stall;
   assign sb.busy_mask = busy;
   assign sb.sb_err    = sb_err_q;

`ifdef SB_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (stats_clr) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard bench for reg_scoreboard
module tb_reg_scoreboard;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] sc_out;

   always #5 clk = ~clk;

   reg_scoreboard_if bus ();

   reg_scoreboard dut (
      .clk          (clk),
      .rst          (rst),
`ifdef SB_STATS_EN
      .stats_clr    (clr),
      .stall_cycles (sc_out),
`endif
      .sb           (bus.slave)
   );

`ifndef SB_STATS_EN
   assign sc_out = 16'h0000;
`endif

   typedef struct packed {
      logic        stall;
      logic [7:0]  busy;
      logic        err;
      logic [15:0] sc;
   } exp_t;

   exp_t q[$];

   // reference model: plain pending-write counts per register
   int pend[8];
   bit m_err;
   int m_sc;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compares whatever the DUT presents against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         check("stall", int'(bus.stall), int'(e.stall));
         check("busy_mask", int'(bus.busy_mask), int'(e.busy));
         check("sb_err", int'(bus.sb_err), int'(e.err));
`ifdef SB_STATS_EN
         check("stall_cycles", int'(sc_out), int'(e.sc));
`endif
      end
   end

   task automatic model_clear();
      for (int r = 0; r < 8; r++) pend[r] = 0;
      m_err = 1'b0;
      m_sc  = 0;
   endtask

   task automatic step(input bit v, input int s, input int d, input bit rs, input bit rd,
                       input bit wr, input bit fl, input bit wv, input int wa,
                       input bit kv, input int ka, input bit c);
      bit   st;
      exp_t e;
      int   nxt[8];
      @(posedge clk);
      #1;
      bus.issue_valid  = v;
      bus.issue_src    = 3'(s);
      bus.issue_dst    = 3'(d);
      bus.issue_rd_src = rs;
      bus.issue_rd_dst = rd;
      bus.issue_wr     = wr;
      bus.flush        = fl;
      bus.wb_valid     = wv;
      bus.wb_addr      = 3'(wa);
      bus.kill_valid   = kv;
      bus.kill_addr    = 3'(ka);
      clr              = c;
      st = v && !fl && ((rs && pend[s] != 0) || (rd && pend[d] != 0) || (wr && pend[d] == 3));
      e.stall = st;
      for (int r = 0; r < 8; r++) e.busy[r] = (pend[r] != 0);
      e.err = m_err;
      e.sc  = 16'(m_sc);
      q.push_back(e);
      if (rst) begin
         nxt = pend;
         if (v && !fl && !st && wr) nxt[d] = nxt[d] + 1;
         if (wv) nxt[wa] = nxt[wa] - 1;
         if (kv) nxt[ka] = nxt[ka] - 1;
         for (int r = 0; r < 8; r++) begin
            if (nxt[r] < 0) begin
               nxt[r] = 0;
               m_err  = 1'b1;
            end
         end
         pend = nxt;
         if (c) m_sc = 0;
         else if (st && m_sc < 65535) m_sc = m_sc + 1;
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr_reg(input int d);
      step(1, 0, d, 0, 0, 1, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd_reg(input int s, input bit wv, input int wa);
      step(1, s, 0, 1, 0, 0, 0, wv, wa, 0, 0, 0);
   endtask

   task automatic wb_reg(input int a);
      step(0, 0, 0, 0, 0, 0, 0, 1, a, 0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();
      for (int i = 0; i < n; i++)
         step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1));
      @(posedge clk);
      #1;
      bus.issue_valid = 1'b0;
      bus.issue_wr    = 1'b0;
      bus.flush       = 1'b0;
      bus.wb_valid    = 1'b0;
      bus.kill_valid  = 1'b0;
      clr             = 1'b0;
      rst             = 1'b1;
   endtask

   function automatic int pick_pending();
      int cand[$];
      for (int r = 0; r < 8; r++) if (pend[r] != 0) cand.push_back(r);
      if (cand.size() == 0 || $urandom_range(0, 9) == 0) return int'($urandom_range(0, 7));
      return cand[$urandom_range(0, cand.size() - 1)];
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      bus.issue_valid = 1'b0;
      bus.issue_src = '0; bus.issue_dst = '0;
      bus.issue_rd_src = 1'b0; bus.issue_rd_dst = 1'b0; bus.issue_wr = 1'b0;
      bus.flush = 1'b0; bus.wb_valid = 1'b0; bus.wb_addr = '0;
      bus.kill_valid = 1'b0; bus.kill_addr = '0;

      do_reset(4);
      idle();

      // RAW on R3: stall holds through the write-back cycle, releases after
      wr_reg(3);
      rd_reg(3, 0, 0);
      rd_reg(3, 0, 0);
      rd_reg(3, 1, 3);
      rd_reg(3, 0, 0);
      idle();

      // saturation on R5
      wr_reg(5); wr_reg(5); wr_reg(5);
      wr_reg(5); wr_reg(5);
      step(1, 0, 5, 0, 0, 1, 0, 1, 5, 0, 0, 0);
      wr_reg(5);
      wb_reg(5); wb_reg(5); wb_reg(5);
      idle();

      // same-edge inc/dec on R2, then double decrement underflow
      wr_reg(2);
      step(1, 0, 2, 0, 0, 1, 0, 1, 2, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2, 0);
      idle();

      // flush never increments or stalls, even against a full register
      wr_reg(1); wr_reg(1); wr_reg(1);
      step(1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      wb_reg(1); wb_reg(1); wb_reg(1);
      // src==dst on idle R4 does not self-stall
      step(1, 4, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0);
      idle();
      wb_reg(4);

      // stall statistics: five stalled cycles, then clear during a stall
      wr_reg(6);
      for (int i = 0; i < 5; i++) rd_reg(6, 0, 0);
      step(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      rd_reg(6, 0, 0);
      rd_reg(6, 1, 6);
      idle();

      // randomized traffic with periodic reset mid-operation
      do_reset(3);
      for (int i = 0; i < 500; i++) begin
         bit wv, kv;
         int wa, ka;
         if (i % 125 == 124) do_reset($urandom_range(1, 3));
         wv = ($urandom_range(0, 2) == 0);
         kv = ($urandom_range(0, 9) == 0);
         wa = pick_pending();
         ka = pick_pending();
         step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7) == 0, wv, wa, kv, ka, $urandom_range(0, 19) == 0);
      end

      idle();
      idle();
      @(negedge clk);
      #1;
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
